mips_muldiv_unit: RTL and testbench
===================================

Name: mips_muldiv_unit

Overview:
- Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
- Operands come from register-file read ports rs/rt (read_data_1/2); the result mux feeds register-file write_data for MFHI/MFLO.
- The controller holds the pipeline on busy; it samples done to retire the op.

Parameters:
- WIDTH, 32, operand and HI/LO width (only 32 is supported).
- CNT_W, 5, iteration counter width (log2 WIDTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request op; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- operand_a  in  32  rs value (multiplicand / dividend).
- operand_b  in  32  rt value (multiplier / divisor).
- mt_hi  in  1  MTHI strobe; loads HI from operand_a.
- mt_lo  in  1  MTLO strobe; loads LO from operand_a.
- hi_sel  in  1  result mux select: 1 = HI, 0 = LO.
- result  out  32  combinational HI or LO for MFHI/MFLO write-back.
- hi  out  32  HI register.
- lo  out  32  LO register.
- busy  out  1  high from the accepted start edge until done.
- done  out  1  one-cycle completion pulse.
- div_by_zero  out  1  sticky; set by DIV/DIVU with operand_b == 0, cleared by the next accepted start.

Behaviour:
- Reset (async): state IDLE, hi = lo = 0, busy = 0, done = 0, div_by_zero = 0, counter = 0.
- Reset mid-operation aborts the op; HI/LO read 0 afterwards.
- States:
  - IDLE: start = 1 at edge N latches op, operand signs and |a|, |b| (signed ops only; unsigned ops use raw values). Clears div_by_zero, sets busy, counter = 0, goes to RUN.
  - RUN: one iteration per edge, N+1 .. N+32; after the iteration with counter = 31, goes to FIX.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring; 33-bit partial remainder, one quotient bit per cycle.
  - FIX: at edge N+33, apply sign correction and write HI/LO, then go to IDLE. done = 1 and busy = 0 during the cycle after N+33.
- Latency: done pulses 34 cycles after the start edge. New HI/LO are visible in that same done cycle.
- Sign rules:
  - MULT: 64-bit product negated if the operand signs differ.
  - DIV: quotient (LO) negated if the signs differ; remainder (HI) takes the sign of the dividend.
  - Unsigned ops: no correction.
  - -2^31 / -1 gives lo = 32'h80000000, hi = 0, with no flag.
- Divide by zero (either signedness):
  - Takes the full 34 cycles.
  - Result lo = 32'hFFFFFFFF, hi = operand_a as latched (original, not magnitude).
  - div_by_zero = 1.
- start while busy: ignored, with no queueing.
- start in the done cycle: accepted (state is IDLE).
- mt_hi / mt_lo:
  - Effective only in IDLE with start = 0; the write occurs at the next edge.
  - Ignored while busy.
  - If asserted together with start, start wins and the mt write is dropped.
  - mt_hi and mt_lo may both be asserted; both registers load operand_a.
- Operand inputs may change after the start edge without affecting the op.
- result = hi_sel ? hi : lo, with no latency.

Optional Feature:
- Macro: MIPS_MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU complete in IDLE -> FIX with a single-cycle signed/unsigned 64-bit multiply.
  - done pulses 2 cycles after the start edge.
  - Divide timing is unchanged.
- Undefined: multiplies use the 32-iteration RUN path, 34-cycle latency.

Test Plan:
- Reset, then MULTU a = 32'hFFFFFFFF, b = 2 -> done at start+34; hi = 1, lo = 32'hFFFFFFFE; busy low with done; (FAST_MUL_EN: done at start+2).
- MULT a = -3, b = 7 -> hi = 32'hFFFFFFFF, lo = 32'hFFFFFFEB. DIV a = -7, b = 2 -> lo = 32'hFFFFFFFD, hi = 32'hFFFFFFFF.
- DIVU a = 100, b = 0 -> lo = 32'hFFFFFFFF, hi = 100, div_by_zero = 1. A following DIVU 100 / 7 clears the flag -> lo = 14, hi = 2.
- DIV a = 32'h80000000, b = 32'hFFFFFFFF -> lo = 32'h80000000, hi = 0, div_by_zero = 0.
- While busy: pulse start with different operands and pulse mt_hi -> both ignored; the original op completes unchanged. In the done cycle, start MULTU 3 * 4 -> accepted, lo = 12.
- Assert reset at start+10 of a DIV -> hi = lo = 0, busy = 0, and no done pulse. Then mt_lo with operand_a = 32'h1234 and hi_sel = 0 -> result = 32'h1234 one edge later.

Source files
------------

// File: rtl/mips_muldiv_if.sv
// Bus between the pipeline controller (master) and the MULT/DIV unit (slave).
interface mips_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             mt_hi;
    logic             mt_lo;
    logic             hi_sel;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, mt_hi, mt_lo, hi_sel,
        input  result, hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, mt_hi, mt_lo, hi_sel,
        output result, hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/mips_muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO registers.
// Define MIPS_MULDIV_FAST_MUL_EN for single-cycle multiplies (divide timing unchanged).
module mips_muldiv_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 5
) (
    input logic          clock,
    input logic          reset,
    mips_muldiv_if.slave bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StFix  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    // Magnitudes of the incoming operands; op[0] = 1 selects the unsigned variants.
    logic             neg_a_in, neg_b_in;
    logic [WIDTH-1:0] a_mag_in, b_mag_in;
    assign neg_a_in = ~bus.op[0] & bus.operand_a[WIDTH-1];
    assign neg_b_in = ~bus.op[0] & bus.operand_b[WIDTH-1];
    assign a_mag_in = neg_a_in ? -bus.operand_a : bus.operand_a;
    assign b_mag_in = neg_b_in ? -bus.operand_b : bus.operand_b;

    // Multiply: acc = {partial product, multiplier}, shifted right once per iteration.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, quotient bits enter at the bottom.
    logic [WIDTH:0]     div_rem_sh;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;
    assign div_rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_ge     = div_rem_sh >= {1'b0, opnd_q};
    assign div_diff   = div_rem_sh[WIDTH-1:0] - opnd_q;
    assign div_step   = {div_ge ? div_diff : div_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;
    assign prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
    assign quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = dbz_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    sign_a_d = neg_a_in;
                    sign_b_d = neg_b_in;
                    a_orig_d = bus.operand_a;
                    opnd_d   = bus.op[1] ? b_mag_in : a_mag_in;
                    acc_d    = {{WIDTH{1'b0}}, bus.op[1] ? a_mag_in : b_mag_in};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    dbz_d    = 1'b0;
                    state_d  = StRun;
`ifdef MIPS_MULDIV_FAST_MUL_EN
                    if (!bus.op[1]) begin
                        acc_d   = (2*WIDTH)'(a_mag_in) * (2*WIDTH)'(b_mag_in);
                        state_d = StFix;
                    end
`endif
                end else begin
                    if (bus.mt_hi) hi_d = bus.operand_a;
                    if (bus.mt_lo) lo_d = bus.operand_a;
                end
            end
            StRun: begin
                acc_d = is_div_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
            end
            StFix: begin
                if (!is_div_q) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (opnd_q == '0) begin
                    // Divide by zero reports the dividend exactly as it arrived.
                    lo_d  = '1;
                    hi_d  = a_orig_q;
                    dbz_d = 1'b1;
                end else begin
                    lo_d = quot_fix;
                    hi_d = rem_fix;
                end
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.result      = bus.hi_sel ? hi_q : lo_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: stimulus pushes model results, a monitor checks on done.
module tb_mips_muldiv_unit;
    logic clock = 1'b0;
    logic reset;

    mips_muldiv_if #(.WIDTH(32)) bus ();

    mips_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

`ifdef MIPS_MULDIV_FAST_MUL_EN
    localparam bit FastMul = 1'b1;
`else
    localparam bit FastMul = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          done_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain SV arithmetic, with the divide-by-zero convention on top.
    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        e.done_cyc = 0;
        case (op)
            2'd0: begin
                p = sa * sb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd1: begin
                p = {32'b0, a} * {32'b0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            2'd2: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                    e.dbz = 1'b1;
                end else begin
                    q = sa / sb;
                    r = sa % sb;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end
            end
            default: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                    e.hi = a;
                    e.dbz = 1'b1;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    function automatic int latency(input logic [1:0] op);
        return (FastMul && !op[1]) ? 2 : 34;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t mon_e;
    always @(negedge clock) begin
        if (!reset && bus.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("done_unexpected", bus.done, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("hi", bus.hi, mon_e.hi);
                check("lo", bus.lo, mon_e.lo);
                check("div_by_zero", bus.div_by_zero, mon_e.dbz);
                check("busy_at_done", bus.busy, 0);
                check("done_latency", cyc, mon_e.done_cyc);
                check("result", bus.result, bus.hi_sel ? mon_e.hi : mon_e.lo);
            end
        end
    end

    // Call between a negedge and the next posedge; returns 1 time unit after the start edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        e = model(op, a, b);
        e.done_cyc = cyc + latency(op);
        sb_q.push_back(e);
        bus.start = 1'b1;
        bus.op = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.op = 2'($urandom);
        bus.operand_a = $urandom;
        bus.operand_b = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 200) begin
            @(negedge clock);
            #1;
            t++;
        end
        check("drain_timeout", sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int          t;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.op = 2'd0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.mt_hi = 1'b0;
        bus.mt_lo = 1'b0;
        bus.hi_sel = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        reset = 1'b0;
        @(negedge clock);

        issue(2'd1, 32'hFFFF_FFFF, 32'd2);
        check("busy_after_start", bus.busy, 1);
        drain();
        issue(2'd0, -32'sd3, 32'd7);
        drain();
        issue(2'd2, -32'sd7, 32'd2);
        drain();
        issue(2'd3, 32'd100, 32'd0);
        drain();
        check("dbz_sticky", bus.div_by_zero, 1);
        issue(2'd3, 32'd100, 32'd7);
        check("dbz_cleared_on_start", bus.div_by_zero, 0);
        drain();
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();

        // start and mt_hi while busy are ignored; start in the done cycle is taken.
        issue(2'd2, 32'd1000, 32'd7);
        repeat (5) @(negedge clock);
        bus.start = 1'b1;
        bus.op = 2'd0;
        bus.operand_a = 32'd55;
        bus.operand_b = 32'd66;
        bus.mt_hi = 1'b1;
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        bus.mt_hi = 1'b0;
        check("busy_hold", bus.busy, 1);
        t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (bus.done !== 1'b1 && t < 100);
        check("done_seen", bus.done, 1);
        issue(2'd1, 32'd3, 32'd4);
        drain();

        // start wins over a simultaneous mt_lo.
        bus.mt_lo = 1'b1;
        issue(2'd1, 32'd5, 32'd6);
        bus.mt_lo = 1'b0;
        check("mt_dropped_with_start", bus.lo, 32'd12);
        drain();

        @(negedge clock);
        bus.mt_hi = 1'b1;
        bus.mt_lo = 1'b1;
        bus.operand_a = 32'hABCD_0123;
        @(posedge clock);
        #1;
        bus.mt_hi = 1'b0;
        bus.mt_lo = 1'b0;
        check("mt_both_hi", bus.hi, 32'hABCD_0123);
        check("mt_both_lo", bus.lo, 32'hABCD_0123);
        bus.hi_sel = 1'b1;
        #1;
        check("result_hi_sel", bus.result, 32'hABCD_0123);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            bus.hi_sel = 1'($urandom);
            issue(2'($urandom), ra, rb);
            drain();
        end

        // Reset 10 edges into a divide aborts it without a done pulse.
        issue(2'd2, -32'sd100, 32'd3);
        sb_q.delete();
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);

        bus.mt_lo = 1'b1;
        bus.operand_a = 32'h1234;
        bus.hi_sel = 1'b0;
        @(posedge clock);
        #1;
        bus.mt_lo = 1'b0;
        check("mtlo_result", bus.result, 32'h1234);
        check("mtlo_hi_untouched", bus.hi, 0);
        repeat (2) @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
